// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 master: FSM state encoding, APB4 pprot
// bit meanings and the width of the ACCESS-phase timeout counter.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // pprot bit meanings (a set bit selects the named attribute)
  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  // Wide enough for the largest legal TIMEOUT (255)
  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/apb4_master.sv
// APB4 master: accepts one request at a time on a valid/ready channel, runs
// it as an APB4 SETUP/ACCESS transfer with a bounded wait on pready, and
// presents the result on a valid/ready response channel.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | req_ready=1, waiting for req_valid
// ST_SETUP  | psel=1, penable=0, exactly one cycle
// ST_ACCESS | psel=1, penable=1, waiting for pready or the timeout count
// ST_RESP   | rsp_valid=1, fields held until rsp_ready
module apb4_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [2:0]          req_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  // Count value seen on the TIMEOUT-th ACCESS cycle (counter starts at 0)
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  apb_state_e           state_q, state_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic [STRB_W-1:0]    pstrb_q, pstrb_d;
  logic [2:0]           pprot_q, pprot_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d   = ST_SETUP;
          cnt_d     = '0;
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_wdata;
          pstrb_d   = req_write ? req_strb : '0;
          pprot_d   = req_prot;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == TMO_LAST) begin
          // Leaving on the terminal count means the counter never wraps
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the next state so it rises the cycle after RESP exits
    req_ready_d = (state_d == ST_IDLE);
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb4_master.md
APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 8, 16 or 32.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles waiting for pready; legal range 1-255.
REQ-004 SHALL have ports: pclk in 1 clock; preset in 1 reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have ports: req_valid in 1, req_ready out 1, req_write in 1, req_addr in ADDR_W, req_wdata in DATA_W, req_strb in DATA_W/8, req_prot in 3 (request channel).
REQ-006 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_W, rsp_err out 1, rsp_timeout out 1 (response channel).
REQ-007 SHALL have APB4 ports: paddr out ADDR_W, psel out 1, penable out 1, pwrite out 1, pwdata out DATA_W, pstrb out DATA_W/8, pprot out 3, prdata in DATA_W, pready in 1, pslverr in 1.

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-009 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1; IDLE->SETUP on acceptance.
REQ-010 On acceptance SHALL register addr, write, wdata, prot and strb; strb SHALL be forced to 0 for reads.
REQ-011 SETUP SHALL last exactly one cycle: psel=1, penable=0; SETUP->ACCESS unconditionally.
REQ-012 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata, pstrb, pprot SHALL stay stable from SETUP until ACCESS exits.
REQ-013 In ACCESS with pready=1: capture prdata (reads; 0 for writes) and pslverr into rsp_rdata/rsp_err, rsp_timeout=0, go to RESP.
REQ-014 SHALL count ACCESS cycles; if pready=0 on the TIMEOUT-th ACCESS cycle: rsp_err=1, rsp_timeout=1, rsp_rdata=0, drop psel/penable, go to RESP.
REQ-015 pready=1 on the TIMEOUT-th cycle SHALL be treated as normal completion, not a timeout.
REQ-016 RESP: rsp_valid=1, rsp fields held stable; RESP->IDLE on rsp_ready=1; psel=penable=0 in RESP and IDLE.
REQ-017 Minimum transaction latency SHALL be 3 cycles from acceptance to rsp_valid (SETUP, one ACCESS, RESP); each wait state adds one cycle.
REQ-018 Back-to-back: a new request SHALL NOT be accepted in the cycle RESP exits; earliest acceptance is the following cycle.
REQ-019 pslverr and prdata SHALL be ignored outside ACCESS-with-pready.
REQ-020 The timeout counter SHALL clear on entry to SETUP and SHALL NOT wrap.

Reset
REQ-021 preset=1 SHALL asynchronously force IDLE, counter=0, and all outputs to 0 except req_ready.
REQ-022 req_ready SHALL read 0 while preset=1 and become 1 on the first pclk edge after preset deasserts.
REQ-023 Reset mid-transaction SHALL abort it silently: psel/penable drop immediately; no response is produced.

Structure
REQ-024 State enum, APB4 prot encodings and TIMEOUT counter width SHALL live in shared package apb_pkg.
REQ-025 The block SHALL be a single module; the timeout counter SHALL be inline with no sub-module.

Verification
REQ-026 Zero-wait write: addr 0x10, wdata 0xA5A5_0001, strb 0xF, pready=1 at once -> psel 2 cycles, penable 1 cycle; rsp_valid 3 cycles after acceptance; rsp_err=0.
REQ-027 Read with 3 wait states: prdata 0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF; pstrb=0; acceptance to rsp_valid is 6 cycles.
REQ-028 Error: pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-029 Timeout, TIMEOUT=4, pready held 0 -> after 4 ACCESS cycles rsp_err=1, rsp_timeout=1, psel drops; pready on the 4th cycle instead -> normal completion.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0 throughout; preset pulse in ACCESS -> psel=0 immediately and no rsp_valid.
